// File: rtl/counter_monitor_pkg.sv
// rtl/counter_monitor_pkg.sv - shared state enum, default widths and the counter step function
package counter_monitor_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_ERR_CNT_W = 8;
  localparam int MAX_WIDTH         = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Computed at MAX_WIDTH; callers truncate to their own width, which gives mod 2^WIDTH wrap.
  function automatic logic [MAX_WIDTH-1:0] step(input logic [MAX_WIDTH-1:0] v,
                                                input logic en,
                                                input logic dir);
    if (!en)
      return v;
    else if (dir)
      return v + MAX_WIDTH'(1);
    else
      return v - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/counter_monitor_if.sv
// rtl/counter_monitor_if.sv - observed-counter stimulus and monitor result signals
interface counter_monitor_if import counter_monitor_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) ();

  logic                 enable;
  logic                 direction;
  logic [WIDTH-1:0]     counter_in;
  logic [WIDTH-1:0]     expected;
  logic                 locked;
  logic                 mismatch;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output enable, direction, counter_in,
    input  expected, locked, mismatch, err, err_count
  );

  modport slave (
    input  enable, direction, counter_in,
    output expected, locked, mismatch, err, err_count
  );

endinterface

// File: rtl/counter_model.sv
// rtl/counter_model.sv - expected-value register advanced by the step function
module counter_model import counter_monitor_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             resync,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] counter_in,
  output logic [WIDTH-1:0] expected
);

  // resync reseeds from the observed value; advance predicts from our own value.
  always_ff @(posedge clk) begin
    if (rst)
      expected <= '0;
    else if (resync)
      expected <= WIDTH'(step(MAX_WIDTH'(counter_in), enable, direction));
    else if (advance)
      expected <= WIDTH'(step(MAX_WIDTH'(expected), enable, direction));
  end

endmodule

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - up/down counter checker FSM; COUNTER_MONITOR_RESYNC_EN enables one-cycle FAULT recovery
module counter_monitor import counter_monitor_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  counter_monitor_if.slave  mon
);

  state_t               state;
  logic [WIDTH-1:0]     expected_q;
  logic                 locked_q;
  logic                 mismatch_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic                 compare;
  logic                 resync;
  logic                 hit;

  assign compare = (state != ST_FAULT);
  assign hit     = (mon.counter_in == expected_q);

`ifdef COUNTER_MONITOR_RESYNC_EN
  assign resync = (state == ST_FAULT);
`else
  assign resync = 1'b0;
`endif

  counter_model #(.WIDTH(WIDTH)) u_model (
    .clk        (clk),
    .rst        (rst),
    .advance    (compare),
    .resync     (resync),
    .enable     (mon.enable),
    .direction  (mon.direction),
    .counter_in (mon.counter_in),
    .expected   (expected_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_TRACK: begin
          mismatch_q <= !hit;
          if (hit) begin
            state    <= ST_TRACK;
            locked_q <= 1'b1;
          end else begin
            state    <= ST_FAULT;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            if (err_count_q != '1)
              err_count_q <= err_count_q + ERR_CNT_W'(1);
          end
        end
        ST_FAULT: begin
          mismatch_q <= 1'b0;
`ifdef COUNTER_MONITOR_RESYNC_EN
          state      <= ST_TRACK;
          locked_q   <= 1'b1;
`else
          state      <= ST_FAULT;
          locked_q   <= 1'b0;
`endif
        end
        default: begin
          state      <= ST_IDLE;
          locked_q   <= 1'b0;
          mismatch_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.expected  = expected_q;
  assign mon.locked    = locked_q;
  assign mon.mismatch  = mismatch_q;
  assign mon.err       = err_q;
  assign mon.err_count = err_count_q;

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - table-driven checks of counter_monitor; COUNTER_MONITOR_RESYNC_EN selects recovery expectations
module tb_counter_monitor;
  import counter_monitor_pkg::*;

  localparam int W = 8;
  localparam int E = 8;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [7:0] cin;
    logic [7:0] x_exp;
    logic       x_lock;
    logic       x_mis;
    logic       x_err;
    logic [7:0] x_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  counter_monitor_if #(.WIDTH(W), .ERR_CNT_W(E)) bus ();

  counter_monitor #(.WIDTH(W), .ERR_CNT_W(E)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_edge(input logic r, input logic en, input logic dir, input logic [7:0] cin);
    rst           = r;
    bus.enable    = en;
    bus.direction = dir;
    bus.counter_in = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [7:0] xe, input logic xl,
                           input logic xm, input logic xerr, input logic [7:0] xc);
    check({name, ".expected"},  bus.expected,  xe);
    check({name, ".locked"},    bus.locked,    xl);
    check({name, ".mismatch"},  bus.mismatch,  xm);
    check({name, ".err"},       bus.err,       xerr);
    check({name, ".err_count"}, bus.err_count, xc);
  endtask

  function automatic void add(input logic r, input logic en, input logic dir, input int cin,
                              input int xe, input logic xl, input logic xm,
                              input logic xerr, input int xc);
    vec_t v;
    v.rst = r; v.en = en; v.dir = dir; v.cin = 8'(cin);
    v.x_exp = 8'(xe); v.x_lock = xl; v.x_mis = xm; v.x_err = xerr; v.x_cnt = 8'(xc);
    tbl.push_back(v);
  endfunction

  initial begin
    // Basic tracking 0..10 (reset applied with enable active must still win)
    add(1, 1, 1, 55, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 10; k++) add(0, 1, 1, k, k + 1, 1, 0, 0, 0);
    // Full up-count through the 255->0 wrap, then down through the 0->255 wrap
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 255; k++) add(0, 1, 1, k, (k + 1) % 256, 1, 0, 0, 0);
    for (int k = 0; k <= 2; k++)   add(0, 1, 1, k, k + 1, 1, 0, 0, 0);
    add(0, 1, 0, 3, 2, 1, 0, 0, 0);
    add(0, 1, 0, 2, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 255, 1, 0, 0, 0);
    add(0, 1, 0, 255, 254, 1, 0, 0, 0);
    add(0, 1, 0, 254, 253, 1, 0, 0, 0);
    add(0, 1, 0, 253, 252, 1, 0, 0, 0);
    // Hold at 7 with enable low, then a single glitch to 8
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 6; k++) add(0, 1, 1, k, k + 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++)  add(0, 0, 1, 7, 7, 1, 0, 0, 0);
    add(0, 0, 1, 8, 7, 0, 1, 1, 1);
`ifdef COUNTER_MONITOR_RESYNC_EN
    add(0, 0, 1, 7, 7, 1, 0, 1, 1);
    add(0, 0, 1, 7, 7, 1, 0, 1, 1);
`else
    add(0, 0, 1, 7, 7, 0, 0, 1, 1);
    add(0, 0, 1, 7, 7, 0, 0, 1, 1);
`endif

    rst = 1'b1; bus.enable = 1'b0; bus.direction = 1'b0; bus.counter_in = '0;
    drive_edge(1, 0, 0, 0);
    check_out("reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive_edge(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].cin);
      check_out($sformatf("vec%0d", i), tbl[i].x_exp, tbl[i].x_lock, tbl[i].x_mis,
                tbl[i].x_err, tbl[i].x_cnt);
    end

    // Mismatch at 20, then the counter reappears at 40
    drive_edge(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive_edge(0, 1, 1, 8'(k));
    check("pre_inject.locked", bus.locked, 1);
    drive_edge(0, 1, 1, 99);
    check_out("inject", 21, 0, 1, 1, 1);
    for (int k = 40; k <= 42; k++) begin
      drive_edge(0, 1, 1, 8'(k));
`ifdef COUNTER_MONITOR_RESYNC_EN
      check_out($sformatf("resync%0d", k), 8'(k + 1), 1, 0, 1, 1);
`else
      check_out($sformatf("frozen%0d", k), 21, 0, 0, 1, 1);
`endif
    end

`ifdef COUNTER_MONITOR_RESYNC_EN
    // Repeated mismatch/recover pairs drive err_count into saturation
    drive_edge(1, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      drive_edge(0, 0, 1, (k % 2 == 0) ? 8'd5 : 8'd0);
      check($sformatf("sat_mis%0d", k), bus.mismatch, 1);
      if (k == 0 || k == 254 || k == 255 || k == 299)
        check($sformatf("sat_cnt%0d", k), bus.err_count, (k >= 254) ? 255 : k + 1);
      drive_edge(0, 0, 1, (k % 2 == 0) ? 8'd5 : 8'd0);
    end
    check("sat.err", bus.err, 1);
    drive_edge(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive_edge(0, 0, 1, (k % 2 == 0) ? 8'd5 : 8'd0);
      if (k < 4) drive_edge(0, 0, 1, (k % 2 == 0) ? 8'd5 : 8'd0);
    end
    check("pre_rst.err_count", bus.err_count, 5);
`else
    drive_edge(1, 0, 0, 0);
    drive_edge(0, 0, 1, 5);
    check("pre_rst.err_count", bus.err_count, 1);
`endif
    // Reset out of FAULT, then the first compare is against 0
    drive_edge(1, 1, 1, 99);
    check_out("rst_in_fault", 0, 0, 0, 0, 0);
    drive_edge(0, 0, 1, 0);
    check_out("post_rst_idle", 0, 1, 0, 0, 0);
    drive_edge(1, 0, 0, 0);
    drive_edge(0, 1, 1, 1);
    check_out("first_cmp_nonzero", 1, 0, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
